uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter for the serial TX path. It succeeds the fixed 8N1 transmitter that needed an external baud clock.

---
 rtl/uart_tx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with internal baud counter.
// Frame = start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_rs232_txd,
  output logic                 o_baudrate_tx_clk_en,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: BAUD_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_d, en_d, busy_d, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Handshake: a request is accepted on any rising edge where the FSM is in
  // S_IDLE and i_tx_start is high; requests at any other time are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = o_rs232_txd;
    en_d    = o_baudrate_tx_clk_en;
    busy_d  = o_tx_busy;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_tx_start) begin
          state_d = S_START;
          shift_d = i_data;
          par_d   = (PARITY == 1) ? ~^i_data : ^i_data;
          txd_d   = 1'b0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // idx_q doubles as the stop-bit counter
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= S_IDLE;
      cnt_q                <= '0;
      idx_q                <= '0;
      shift_q              <= '0;
      par_q                <= 1'b0;
      o_rs232_txd          <= 1'b1;
      o_baudrate_tx_clk_en <= 1'b0;
      o_tx_busy            <= 1'b0;
      o_tx_done            <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      idx_q                <= idx_d;
      shift_q              <= shift_d;
      par_q                <= par_d;
      o_rs232_txd          <= txd_d;
      o_baudrate_tx_clk_en <= en_d;
      o_tx_busy            <= busy_d;
      o_tx_done            <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: six instances cover default, 7-bit/2-stop
// parity, and 8-bit divide-by-4 configurations; all share clk and rst_n.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] start;
  logic [8:0] data [6];
  wire  [5:0] txd, clk_en, busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  // index 0: defaults (BAUD_DIV 434, 8N1)
  uart_tx_frame u_def (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[0]), .i_data(data[0][7:0]),
    .o_rs232_txd(txd[0]), .o_baudrate_tx_clk_en(clk_en[0]),
    .o_tx_busy(busy[0]), .o_tx_done(done[0]));
  // index 1: DIV4, 7 bits, even parity, 2 stop
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[1]), .i_data(data[1][6:0]),
    .o_rs232_txd(txd[1]), .o_baudrate_tx_clk_en(clk_en[1]),
    .o_tx_busy(busy[1]), .o_tx_done(done[1]));
  // index 2: DIV4, 7 bits, odd parity, 2 stop
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[2]), .i_data(data[2][6:0]),
    .o_rs232_txd(txd[2]), .o_baudrate_tx_clk_en(clk_en[2]),
    .o_tx_busy(busy[2]), .o_tx_done(done[2]));
  // index 3..5: DIV4 8N1, 8O1, 8E1
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[3]), .i_data(data[3][7:0]),
    .o_rs232_txd(txd[3]), .o_baudrate_tx_clk_en(clk_en[3]),
    .o_tx_busy(busy[3]), .o_tx_done(done[3]));
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[4]), .i_data(data[4][7:0]),
    .o_rs232_txd(txd[4]), .o_baudrate_tx_clk_en(clk_en[4]),
    .o_tx_busy(busy[4]), .o_tx_done(done[4]));
  uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(250_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .i_tx_start(start[5]), .i_data(data[5][7:0]),
    .o_rs232_txd(txd[5]), .o_baudrate_tx_clk_en(clk_en[5]),
    .o_tx_busy(busy[5]), .o_tx_done(done[5]));

  // Driver + line monitor: pulses start for one cycle, scrambles i_data after
  // the accept edge, and samples the line on falling edges. t = 0 is the
  // falling edge right after the accept edge; bit b covers t = b*div..b*div+div-1.
  task automatic run_frame(input int k, input int div, input int nbits, input logic [8:0] word,
                           output logic [15:0] bits, output int done_t, output int done_cnt,
                           output int glitches, output logic busy0);
    logic cur;
    bits = '0; done_t = -1; done_cnt = 0; glitches = 0; cur = 1'b1;
    @(negedge clk);
    data[k] = word;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    data[k] = ~word;
    busy0 = busy[k];
    for (int t = 0; t < nbits * div + 3; t++) begin
      if (t < nbits * div) begin
        if (t % div == 0) cur = txd[k];
        else if (txd[k] !== cur) glitches++;
        if (t % div == div / 2) bits[t / div] = txd[k];
      end
      if (done[k] === 1'b1) begin
        if (done_t < 0) done_t = t;
        done_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = '0;
    for (int i = 0; i < 6; i++) data[i] = '0;
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (txd !== 6'h3F) begin n_err++; $display("FAIL reset_txd: got %b want %b", txd, 6'h3F); end
    n_vec++; if (busy !== 6'h00) begin n_err++; $display("FAIL reset_busy: got %b want %b", busy, 6'h00); end
    n_vec++; if (clk_en !== 6'h00) begin n_err++; $display("FAIL reset_clk_en: got %b want %b", clk_en, 6'h00); end
    n_vec++; if (done !== 6'h00) begin n_err++; $display("FAIL reset_done: got %b want %b", done, 6'h00); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (txd !== 6'h3F) begin n_err++; $display("FAIL idle_txd: got %b want %b", txd, 6'h3F); end
    n_vec++; if (busy !== 6'h00) begin n_err++; $display("FAIL idle_busy: got %b want %b", busy, 6'h00); end
  endtask

  task automatic test_default_frame();
    logic [15:0] bits; int dt, dc, gl; logic b0;
    run_frame(0, 434, 10, 9'h0A5, bits, dt, dc, gl, b0);
    n_vec++; if (bits[9:0] !== 10'h34A) begin n_err++; $display("FAIL def_bits: got %h want %h", bits[9:0], 10'h34A); end
    n_vec++; if (gl !== 0) begin n_err++; $display("FAIL def_bit_hold: got %0d glitches want 0", gl); end
    n_vec++; if (dt !== 4340) begin n_err++; $display("FAIL def_done_time: got %0d want 4340", dt); end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL def_done_count: got %0d want 1", dc); end
    n_vec++; if (b0 !== 1'b1) begin n_err++; $display("FAIL def_busy_at_accept: got %b want 1", b0); end
    n_vec++; if (clk_en[0] !== 1'b0) begin n_err++; $display("FAIL def_clk_en_after: got %b want 0", clk_en[0]); end
  endtask

  task automatic test_parity();
    logic [15:0] bits; int dt, dc, gl; logic b0;
    run_frame(1, 4, 11, 9'h055, bits, dt, dc, gl, b0);
    n_vec++; if (bits[10:0] !== 11'h6AA) begin n_err++; $display("FAIL even_bits: got %h want %h", bits[10:0], 11'h6AA); end
    n_vec++; if (dt !== 44) begin n_err++; $display("FAIL even_done_time: got %0d want 44", dt); end
    run_frame(2, 4, 11, 9'h055, bits, dt, dc, gl, b0);
    n_vec++; if (bits[10:0] !== 11'h7AA) begin n_err++; $display("FAIL odd_bits: got %h want %h", bits[10:0], 11'h7AA); end
    n_vec++; if (dt !== 44) begin n_err++; $display("FAIL odd_done_time: got %0d want 44", dt); end
    n_vec++; if (gl !== 0) begin n_err++; $display("FAIL odd_bit_hold: got %0d glitches want 0", gl); end
  endtask

  task automatic test_back_to_back();
    logic       line [140];
    logic [9:0] exp_f [3];
    logic [9:0] got;
    int         dt [3];
    int         dc;
    exp_f = '{10'h200, 10'h3FE, 10'h278};
    dc = 0;
    @(negedge clk);
    data[3] = 9'h000;
    start[3] = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 140; t++) begin
      line[t] = txd[3];
      if (done[3] === 1'b1) begin
        if (dc < 3) dt[dc] = t;
        dc++;
      end
      if (t == 0) data[3] = 9'h0FF;
      if (t == 41) data[3] = 9'h03C;
      if (t == 82) start[3] = 1'b0;
      @(negedge clk);
    end
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 10; b++) got[b] = line[41 * f + 4 * b + 2];
      n_vec++; if (got !== exp_f[f]) begin n_err++; $display("FAIL b2b_frame%0d: got %h want %h", f, got, exp_f[f]); end
    end
    n_vec++; if (dc !== 3) begin n_err++; $display("FAIL b2b_done_count: got %0d want 3", dc); end
    n_vec++; if (dt[0] !== 40 || dt[1] !== 81 || dt[2] !== 122) begin
      n_err++; $display("FAIL b2b_done_times: got %0d %0d %0d want 40 81 122", dt[0], dt[1], dt[2]);
    end
    n_vec++; if ({line[40], line[41], line[81], line[82]} !== 4'b1010) begin
      n_err++; $display("FAIL b2b_gap: got %b want 1010", {line[40], line[41], line[81], line[82]});
    end
  endtask

  task automatic test_ignore_start();
    logic [9:0] got;
    int dt, dc, late_low;
    dt = -1; dc = 0; late_low = 0; got = '0;
    @(negedge clk);
    data[3] = 9'h05A;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (t < 40 && t % 4 == 2) got[t / 4] = txd[3];
      if (t > 40 && txd[3] !== 1'b1) late_low++;
      if (done[3] === 1'b1) begin
        if (dt < 0) dt = t;
        dc++;
      end
      if (t == 10) begin start[3] = 1'b1; data[3] = 9'h0C3; end
      if (t == 11) start[3] = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (got !== 10'h2B4) begin n_err++; $display("FAIL ign_bits: got %h want %h", got, 10'h2B4); end
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", dc); end
    n_vec++; if (dt !== 40) begin n_err++; $display("FAIL ign_done_time: got %0d want 40", dt); end
    n_vec++; if (late_low !== 0) begin n_err++; $display("FAIL ign_no_second_frame: got %0d low cycles want 0", late_low); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] bits; int dt, dc, gl; logic b0;
    int stray;
    stray = 0;
    @(negedge clk);
    data[3] = 9'h000;
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    repeat (13) @(negedge clk);
    n_vec++; if (txd[3] !== 1'b0) begin n_err++; $display("FAIL abort_pre_line: got %b want 0", txd[3]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (txd[3] !== 1'b1) begin n_err++; $display("FAIL abort_line: got %b want 1", txd[3]); end
    n_vec++; if (busy[3] !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy[3]); end
    n_vec++; if (clk_en[3] !== 1'b0) begin n_err++; $display("FAIL abort_clk_en: got %b want 0", clk_en[3]); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 4) rst_n = 1'b1;
      if (done[3] === 1'b1) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", stray); end
    run_frame(3, 4, 10, 9'h0A5, bits, dt, dc, gl, b0);
    n_vec++; if (bits[9:0] !== 10'h34A) begin n_err++; $display("FAIL abort_next_bits: got %h want %h", bits[9:0], 10'h34A); end
    n_vec++; if (dt !== 40 || dc !== 1) begin n_err++; $display("FAIL abort_next_done: got t=%0d n=%0d want t=40 n=1", dt, dc); end
  endtask

  task automatic test_random();
    logic [15:0] bits, exp_bits;
    logic [7:0]  w;
    logic        par;
    int          k, nbits, dt, dc, gl;
    logic        b0;
    for (int i = 0; i < 200; i++) begin
      k = 3 + (i % 3);
      w = 8'($urandom_range(0, 255));
      par = (k == 4) ? ~^w : ^w;
      if (k == 3) begin
        nbits = 10;
        exp_bits = {6'b0, 1'b1, w, 1'b0};
      end else begin
        nbits = 11;
        exp_bits = {5'b0, 1'b1, par, w, 1'b0};
      end
      run_frame(k, 4, nbits, {1'b0, w}, bits, dt, dc, gl, b0);
      n_vec++; if (bits !== exp_bits) begin n_err++; $display("FAIL rand_bits[%0d] inst%0d: got %h want %h", i, k, bits, exp_bits); end
      n_vec++; if (dt !== nbits * 4) begin n_err++; $display("FAIL rand_done[%0d] inst%0d: got %0d want %0d", i, k, dt, nbits * 4); end
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
